// File: rtl/timer_pkg.sv
// Shared constants for the memory-mapped interval timer: register offsets,
// TCON bit positions and the default base address of the register window.
package timer_pkg;

    localparam logic [31:0] TIMER_BASE     = 32'h4000_0000;

    localparam logic [3:0]  TIMER_TH_OFS   = 4'h0;
    localparam logic [3:0]  TIMER_TL_OFS   = 4'h4;
    localparam logic [3:0]  TIMER_TCON_OFS = 4'h8;
    localparam logic [3:0]  TIMER_PSC_OFS  = 4'hC;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale tick generator: asserts tick once every (psc+1) enabled cycles.
// Only instantiated when TIMER_PRESCALE_EN is defined.
module timer_prescaler (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    input  logic [15:0] psc,
    output logic        tick
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign tick = (cnt_q == psc);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 16'd0;
        end else if (en) begin
            cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_irq.sv
// Memory-mapped interval timer with sticky overflow flag driving the CPU IRQ.
// Optional prescaler at offset 0xC is enabled by defining TIMER_PRESCALE_EN.
module timer_irq
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = TIMER_BASE,
    parameter logic [31:0] RESET_TH  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        IRQ
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        st_q, st_d;

    logic        hit;
    logic [3:0]  ofs;
    logic        wr_th, wr_tl, wr_tcon;
    logic        tick;
    logic        count;
    logic        ovf;
    logic        unused_addr_bits;

    assign hit              = (Address[31:4] == BASE_ADDR[31:4]);
    assign ofs              = {Address[3:2], 2'b00};
    assign unused_addr_bits = ^Address[1:0];

    assign wr_th   = MemWrite && hit && (ofs == TIMER_TH_OFS);
    assign wr_tl   = MemWrite && hit && (ofs == TIMER_TL_OFS);
    assign wr_tcon = MemWrite && hit && (ofs == TIMER_TCON_OFS);

`ifdef TIMER_PRESCALE_EN
    logic [15:0] psc_q, psc_d;
    logic        wr_psc;
    logic        psc_clr;

    assign wr_psc  = MemWrite && hit && (ofs == TIMER_PSC_OFS);
    assign psc_clr = wr_tcon && !WriteData[TCON_EN];

    always_comb begin
        psc_d = psc_q;
        if (wr_psc) begin
            psc_d = WriteData[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc_q <= 16'd0;
        end else begin
            psc_q <= psc_d;
        end
    end

    timer_prescaler u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en_q),
        .clr   (psc_clr),
        .psc   (psc_q),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign count = en_q && tick;
    assign ovf   = count && (tl_q == 32'hFFFF_FFFF);

    // Bus writes beat the counter on TL; an overflow set of ST beats a TCON clear
    always_comb begin
        th_d = th_q;
        tl_d = tl_q;
        en_d = en_q;
        ie_d = ie_q;
        st_d = st_q;

        if (count) begin
            tl_d = ovf ? th_q : tl_q + 32'd1;
        end
        if (wr_tl) begin
            tl_d = WriteData;
        end
        if (wr_th) begin
            th_d = WriteData;
        end
        if (wr_tcon) begin
            en_d = WriteData[TCON_EN];
            ie_d = WriteData[TCON_IE];
            st_d = WriteData[TCON_ST];
        end
        if (ovf && ie_q) begin
            st_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q <= RESET_TH;
            tl_q <= 32'd0;
            en_q <= 1'b0;
            ie_q <= 1'b0;
            st_q <= 1'b0;
        end else begin
            th_q <= th_d;
            tl_q <= tl_d;
            en_q <= en_d;
            ie_q <= ie_d;
            st_q <= st_d;
        end
    end

    always_comb begin
        ReadData = 32'h0;
        if (MemRead && hit) begin
            case (ofs)
                TIMER_TH_OFS:   ReadData = th_q;
                TIMER_TL_OFS:   ReadData = tl_q;
                TIMER_TCON_OFS: ReadData = {29'd0, st_q, ie_q, en_q};
`ifdef TIMER_PRESCALE_EN
                TIMER_PSC_OFS:  ReadData = {16'd0, psc_q};
`endif
                default:        ReadData = 32'h0;
            endcase
        end
    end

    assign IRQ = st_q & ie_q;

endmodule
